// File: rtl/program_rom_loader.sv
// Reloadable instruction memory for the TD4 core: a host streams a program plus a
// two's-complement checksum, and the core is held in reset until a load verifies.
module program_rom_loader #(
  parameter int addrWidth = 4,
  parameter int dataWidth = 8
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [addrWidth-1:0] A,
  output logic [dataWidth-1:0] D,
  output logic                 HOLD,
  input  logic                 LD_START,
  input  logic                 LD_VALID,
  input  logic [dataWidth-1:0] LD_DATA,
  output logic                 LD_READY,
  output logic                 LOADED,
  output logic                 ERR,
  output logic [addrWidth-1:0] WPTR
);

  localparam int DEPTH = 1 << addrWidth;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [addrWidth-1:0] wptr_q, wptr_d;
  logic [dataWidth-1:0] sum_q, sum_d;
  logic [dataWidth-1:0] mem_q [DEPTH];
  logic                 hold_q, hold_d;
  logic                 ready_q, ready_d;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;
  logic                 we_s;
  logic                 xfer_s;
  logic [dataWidth-1:0] sum_next_s;

  assign xfer_s     = LD_VALID & ready_q;
  assign sum_next_s = sum_q + LD_DATA;

  // State, pointer, running sum and registered output flags
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= ST_EMPTY;
      wptr_q   <= {addrWidth{1'b0}};
      sum_q    <= {dataWidth{1'b0}};
      hold_q   <= 1'b1;
      ready_q  <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      sum_q    <= sum_d;
      hold_q   <= hold_d;
      ready_q  <= ready_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // Program memory: flop array so reset can clear every word and reads stay asynchronous
  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {dataWidth{1'b0}};
      end
    end else if (we_s) begin
      mem_q[wptr_q] <= LD_DATA;
    end else begin
      mem_q[wptr_q] <= mem_q[wptr_q];
    end
  end

  // Next-state logic; LD_START always wins over a same-cycle transfer
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    sum_d   = sum_q;
    we_s    = 1'b0;
    case (state_q)
      ST_EMPTY, ST_RUN, ST_ERROR: begin
        if (LD_START) begin
          state_d = ST_LOAD;
          wptr_d  = {addrWidth{1'b0}};
          sum_d   = {dataWidth{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (LD_START) begin
          wptr_d = {addrWidth{1'b0}};
          sum_d  = {dataWidth{1'b0}};
        end else if (xfer_s) begin
          we_s   = 1'b1;
          sum_d  = sum_next_s;
          wptr_d = wptr_q + {{(addrWidth-1){1'b0}}, 1'b1};
          if (wptr_q == {addrWidth{1'b1}}) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CHECK: begin
        if (LD_START) begin
          state_d = ST_LOAD;
          wptr_d  = {addrWidth{1'b0}};
          sum_d   = {dataWidth{1'b0}};
        end else if (xfer_s) begin
          if (sum_next_s == {dataWidth{1'b0}}) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        wptr_d  = {addrWidth{1'b0}};
        sum_d   = {dataWidth{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so the flags change on the deciding edge
  always_comb begin
    hold_d   = 1'b1;
    ready_d  = 1'b0;
    loaded_d = 1'b0;
    err_d    = 1'b0;
    case (state_d)
      ST_EMPTY: begin
        hold_d = 1'b1;
      end
      ST_LOAD, ST_CHECK: begin
        ready_d = 1'b1;
      end
      ST_RUN: begin
        hold_d   = 1'b0;
        loaded_d = 1'b1;
      end
      ST_ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        hold_d = 1'b1;
      end
    endcase
  end

  assign D        = hold_q ? {dataWidth{1'b0}} : mem_q[A];
  assign HOLD     = hold_q;
  assign LD_READY = ready_q;
  assign LOADED   = loaded_q;
  assign ERR      = err_q;
  assign WPTR     = wptr_q;

endmodule

// File: tb/tb_program_rom_loader.sv
// Directed bench for program_rom_loader: good/bad checksum, gaps, restart, reset, reload.
module tb_program_rom_loader;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [3:0] A = 4'd0;
  logic [7:0] D;
  logic       HOLD;
  logic       LD_START = 1'b0;
  logic       LD_VALID = 1'b0;
  logic [7:0] LD_DATA = 8'd0;
  logic       LD_READY;
  logic       LOADED;
  logic       ERR;
  logic [3:0] WPTR;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] prog [16];

  program_rom_loader #(.addrWidth(4), .dataWidth(8)) dut (
    .CLK(CLK), .CLR(CLR), .A(A), .D(D), .HOLD(HOLD),
    .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
    .LD_READY(LD_READY), .LOADED(LOADED), .ERR(ERR), .WPTR(WPTR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] cks_of();
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 16; i++) s = s + prog[i];
    return 8'd0 - s;
  endfunction

  task automatic send(input logic [7:0] b);
    int w = 0;
    LD_VALID = 1'b1;
    LD_DATA  = b;
    while (!LD_READY && w < 20) begin
      tick();
      w++;
    end
    if (!LD_READY) chk("ready_timeout", {31'd0, LD_READY}, 32'd1);
    tick();
  endtask

  task automatic load_prog(input bit do_start, input logic [7:0] cks, input bit gaps);
    if (do_start) begin
      LD_START = 1'b1;
      tick();
      LD_START = 1'b0;
      chk("start_hold", {31'd0, HOLD}, 32'd1);
      chk("start_wptr", {28'd0, WPTR}, 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        LD_VALID = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        chk("gap_wptr", {28'd0, WPTR}, i);
      end
      send(prog[i]);
      chk("load_hold", {31'd0, HOLD}, 32'd1);
    end
    chk("check_wptr", {28'd0, WPTR}, 32'd0);
    chk("check_rdy", {31'd0, LD_READY}, 32'd1);
    send(cks);
    LD_VALID = 1'b0;
  endtask

  task automatic verify_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      A = a[3:0];
      #1;
      chk(tag, {24'd0, D}, {24'd0, prog[a]});
    end
  endtask

  task automatic expect_run(input string tag);
    chk({tag, "_loaded"}, {31'd0, LOADED}, 32'd1);
    chk({tag, "_hold"}, {31'd0, HOLD}, 32'd0);
    chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_hold", {31'd0, HOLD}, 32'd1);
    chk("rst_ready", {31'd0, LD_READY}, 32'd0);
    chk("rst_loaded", {31'd0, LOADED}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_wptr", {28'd0, WPTR}, 32'd0);
    chk("rst_d", {24'd0, D}, 32'd0);
    CLR = 1'b0;

    // valid without start in EMPTY is ignored
    LD_VALID = 1'b1; LD_DATA = 8'h55;
    tick(); tick();
    LD_VALID = 1'b0;
    chk("empty_wptr", {28'd0, WPTR}, 32'd0);
    chk("empty_ready", {31'd0, LD_READY}, 32'd0);

    // good load 0x00..0x0F, checksum 0x88
    for (int i = 0; i < 16; i++) prog[i] = i[7:0];
    load_prog(1'b1, 8'h88, 1'b0);
    expect_run("good");
    chk("good_ready", {31'd0, LD_READY}, 32'd0);
    A = 4'd5;  #1; chk("good_d5", {24'd0, D}, 32'h05);
    A = 4'd15; #1; chk("good_d15", {24'd0, D}, 32'h0F);

    // bad checksum 0x87
    load_prog(1'b1, 8'h87, 1'b0);
    chk("bad_err", {31'd0, ERR}, 32'd1);
    chk("bad_hold", {31'd0, HOLD}, 32'd1);
    chk("bad_loaded", {31'd0, LOADED}, 32'd0);
    A = 4'd3; #1; chk("bad_d", {24'd0, D}, 32'd0);
    load_prog(1'b1, 8'h88, 1'b0);
    expect_run("recover");

    // gaps, bytes 0xA0..0xAF; sum 0x78 -> checksum 0x88
    for (int i = 0; i < 16; i++) prog[i] = 8'hA0 + i[7:0];
    chk("gap_cks_model", {24'd0, cks_of()}, 32'h88);
    load_prog(1'b1, cks_of(), 1'b1);
    expect_run("gaps");
    verify_mem("gaps_mem");

    // restart mid-load: 7 bytes, then start with a 0xFF transfer that must be dropped
    LD_START = 1'b1; tick(); LD_START = 1'b0;
    for (int i = 0; i < 7; i++) send(8'h30 + i[7:0]);
    chk("restart_pre_wptr", {28'd0, WPTR}, 32'd7);
    LD_START = 1'b1; LD_VALID = 1'b1; LD_DATA = 8'hFF;
    tick();
    LD_START = 1'b0; LD_VALID = 1'b0;
    chk("restart_wptr", {28'd0, WPTR}, 32'd0);
    chk("restart_ready", {31'd0, LD_READY}, 32'd1);
    for (int i = 0; i < 16; i++) prog[i] = 8'h50 + i[7:0];
    load_prog(1'b0, cks_of(), 1'b0);
    expect_run("restart");
    verify_mem("restart_mem");

    // reset after 10 bytes
    LD_START = 1'b1; tick(); LD_START = 1'b0;
    for (int i = 0; i < 10; i++) send(8'h77);
    LD_VALID = 1'b0;
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("clr_ready", {31'd0, LD_READY}, 32'd0);
    chk("clr_wptr", {28'd0, WPTR}, 32'd0);
    chk("clr_hold", {31'd0, HOLD}, 32'd1);
    chk("clr_loaded", {31'd0, LOADED}, 32'd0);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    load_prog(1'b1, 8'h00, 1'b0);
    expect_run("zeros");
    verify_mem("zeros_mem");

    // reload while running
    A = 4'd2;
    LD_START = 1'b1; tick(); LD_START = 1'b0;
    chk("reload_hold", {31'd0, HOLD}, 32'd1);
    chk("reload_loaded", {31'd0, LOADED}, 32'd0);
    chk("reload_d", {24'd0, D}, 32'd0);
    for (int i = 0; i < 16; i++) prog[i] = 8'h11 * i[7:0];
    load_prog(1'b0, cks_of(), 1'b0);
    expect_run("reload");
    verify_mem("reload_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_rom_loader.md
Name: program_rom_loader

Overview:
- Writable instruction memory that sits directly upstream of the TD4 core.
- The core drives the address into it and receives the fetched instruction byte back.
- A host streams a program in over a valid/ready byte interface, followed by a two's-complement checksum byte. The core is held in reset until a load completes and passes its checksum.
- Makes the fixed program ROM field-reloadable without resynthesis.

Parameters:
addrWidth, 4, width of the fetch address; memory depth = 2**addrWidth
dataWidth, 8, instruction/load byte width

Ports:
CLK  input  1  system clock; all state changes on rising edge
CLR  input  1  reset, synchronous, active-high
A  input  addrWidth  fetch address from core PC
D  output  dataWidth  instruction byte to core
HOLD  output  1  drives core CLR; 1 = core held in reset
LD_START  input  1  one-cycle pulse: begin (re)load
LD_VALID  input  1  host byte valid
LD_DATA  input  dataWidth  host byte
LD_READY  output  1  loader accepts a byte this cycle
LOADED  output  1  program valid, core running
ERR  output  1  last load failed its checksum
WPTR  output  addrWidth  next memory write index (debug)

Behaviour:
- Clock and reset: one clock, CLK. Reset CLR is synchronous and active-high, and it has priority over every other input.
- Reset values: state=EMPTY, all memory words=0, WPTR=0, running sum=0, HOLD=1, LD_READY=0, LOADED=0, ERR=0, D=0.
- Handshake: a byte transfers on a rising edge where LD_VALID=1 and LD_READY=1. The host may hold LD_VALID indefinitely. Gaps in LD_VALID are legal.
- LD_READY is a registered function of state: 1 in LOAD and CHECK, 0 otherwise.
- States:
  - EMPTY: HOLD=1. LD_START -> LOAD with WPTR=0, sum=0. LD_VALID is ignored.
  - LOAD: each transfer writes mem[WPTR]=LD_DATA, sets sum=(sum+LD_DATA) mod 2**dataWidth, and increments WPTR. The transfer at WPTR=depth-1 wraps WPTR to 0 and moves to CHECK.
  - CHECK: accepts exactly one byte (the checksum), which is not written to memory.
    - If (sum+byte) mod 2**dataWidth == 0 -> RUN.
    - Otherwise -> ERROR.
  - RUN: HOLD=0, LOADED=1, ERR=0. LD_START -> LOAD, and memory is overwritten progressively.
  - ERROR: HOLD=1, ERR=1, LOADED=0. LD_START -> LOAD (ERR clears on entry to LOAD).
- Outputs are registered from next-state:
  - HOLD falls on the edge that accepts a good checksum.
  - HOLD rises on the edge that samples LD_START in RUN.
- LD_START in LOAD or CHECK restarts the load: WPTR=0, sum=0, state=LOAD. A handshake in the same cycle is discarded; no write, no sum update.
- LD_START and a transfer in EMPTY, RUN or ERROR in the same cycle: only the start takes effect.
- Fetch path: D = mem[A] combinationally (asynchronous read) when HOLD=0. D = 0 whenever HOLD=1, so the core sees a harmless opcode.
- Write-to-read visibility: a write lands on the edge. A fetch of that address in a later cycle returns the new value.
- CLR mid-load: all memory is cleared and the load is abandoned. The host must pulse LD_START again.
- Arithmetic: sum and checksum are modulo 2**dataWidth; carries are discarded. WPTR wraps modulo depth.
- Implementation: memory is an explicit register array, not an inferred RAM block, so that reset clearing and async read hold.

Test Plan:
- Good load: CLR, then LD_START, then bytes 0x00..0x0F back-to-back, then checksum 0x88 -> HOLD=1 throughout the load. On the checksum edge: LOADED=1, HOLD=0, ERR=0. Then A=5 -> D=0x05 and A=15 -> D=0x0F.
- Bad checksum: same 16 bytes, then checksum 0x87 -> ERR=1, HOLD=1, LOADED=0, D=0x00 for any A. Then LD_START plus a correct stream -> RUN, ERR=0.
- Backpressure and gaps: LD_VALID toggled 1-0-1 with random gaps over the bytes 0xA0..0xAF, checksum 0x00+... (computed modulo 256) -> every byte written exactly once. WPTR steps only on handshakes and reads 0 on entry to CHECK.
- Restart mid-load: after 7 bytes, LD_START is pulsed with LD_VALID=1, LD_DATA=0xFF -> 0xFF is not written and WPTR=0. A fresh 16-byte load plus checksum reaches RUN, and mem[0..6] hold the new values.
- Reset mid-load: CLR asserted after 10 bytes -> next cycle state EMPTY, LD_READY=0, WPTR=0, all words read back 0 after a subsequent good load of zeros with checksum 0x00.
- Reload while running: in RUN, LD_START -> HOLD=1 and LOADED=0 on the next edge, D=0x00. A new program with a valid checksum returns to RUN with the new contents at every address.
